ptr_cdc_sync_mc: RTL and testbench

Multi-channel, parametrised-depth Gray-pointer synchronizer for the async FIFO library. It carries NUM_CH Gray-coded pointers across the clock boundary into the `clk` domain through a SYNC_STAGE-deep flop chain. It also provides a registered Gray-to-binary conversion, a per-channel pointer-advance count, an update strobe, and a sticky illegal-Gray-transition error flag. It sits on the destination side of each FIFO pointer crossing and feeds the full/empty and level logic directly.

---
 rtl/fifo_cdc_pkg.sv | 35 +++
 rtl/ptr_cdc_sync_mc_if.sv | 25 ++
 rtl/ptr_sync_chan.sv | 80 ++++++++
 rtl/ptr_cdc_sync_mc.sv | 46 ++++
 tb/tb_ptr_cdc_sync_mc.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO pointer crossings: Gray/binary conversion,
// popcount and synchronizer depth limits.
package fifo_cdc_pkg;

  localparam int unsigned SYNC_STAGE_MIN = 2;
  localparam int unsigned SYNC_STAGE_MAX = 4;
  localparam int unsigned NUM_CH_MIN     = 1;
  localparam int unsigned NUM_CH_MAX     = 8;
  localparam int unsigned GRAY_W_MAX     = 16;

  // Operands are zero-extended to GRAY_W_MAX, so the result is exact for any
  // narrower width once cast back down.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int unsigned i = GRAY_W_MAX-1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_W_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < GRAY_W_MAX; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ptr_cdc_sync_mc_if.sv
// Pointer bus between the source-side pointer logic and the synchronizer.
interface ptr_cdc_sync_mc_if #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned NUM_CH        = 1
);
  localparam int unsigned PW = ADDRESS_WIDTH + 1;

  logic [NUM_CH*PW-1:0] din;
  logic [NUM_CH-1:0]    err_clr;
  logic [NUM_CH*PW-1:0] sync_gray;
  logic [NUM_CH*PW-1:0] sync_bin;
  logic [NUM_CH-1:0]    upd;
  logic [NUM_CH*PW-1:0] adv;
  logic [NUM_CH-1:0]    gray_err;

  modport master (
    output din, err_clr,
    input  sync_gray, sync_bin, upd, adv, gray_err
  );

  modport slave (
    input  din, err_clr,
    output sync_gray, sync_bin, upd, adv, gray_err
  );
endinterface

// File: rtl/ptr_sync_chan.sv
// One pointer channel: synchronizer chain, registered Gray-to-binary,
// change/advance detection and sticky illegal-step flag.
module ptr_sync_chan
  import fifo_cdc_pkg::*;
#(
  parameter int unsigned PW         = 5,
  parameter int unsigned SYNC_STAGE = 2,
  parameter bit          GRAY_CHECK = 1'b1
) (
  input  logic          clk,
  input  logic          s_rst,
  input  logic [PW-1:0] din,
  input  logic          err_clr,
  output logic [PW-1:0] sync_gray,
  output logic [PW-1:0] sync_bin,
  output logic          upd,
  output logic [PW-1:0] adv,
  output logic          gray_err
);

  (* ASYNC_REG = "TRUE" *) logic [PW-1:0] stage [SYNC_STAGE];
  logic [PW-1:0] gray_prev;
  logic [PW-1:0] bin_now;
  logic          chg;
  logic          multi_bit;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      for (int unsigned k = 0; k < SYNC_STAGE; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned k = 1; k < SYNC_STAGE; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign sync_gray = stage[SYNC_STAGE-1];

  always_comb begin
    bin_now   = PW'(gray2bin(GRAY_W_MAX'(sync_gray)));
    chg       = (sync_gray != gray_prev);
    multi_bit = (popcount(GRAY_W_MAX'(sync_gray ^ gray_prev)) > 1);
  end

  // sync_bin still holds the previous pointer's binary value, so it doubles
  // as bin_prev for the advance.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      gray_prev <= '0;
      sync_bin  <= '0;
      upd       <= 1'b0;
      adv       <= '0;
    end else begin
      gray_prev <= sync_gray;
      sync_bin  <= bin_now;
      upd       <= chg;
      adv       <= chg ? (bin_now - sync_bin) : '0;
    end
  end

  if (GRAY_CHECK) begin : g_check
    always_ff @(posedge clk) begin
      if (s_rst) begin
        gray_err <= 1'b0;
      end else if (multi_bit) begin
        gray_err <= 1'b1;
      end else if (err_clr) begin
        gray_err <= 1'b0;
      end
    end
  end else begin : g_nocheck
    logic unused_chk;
    assign unused_chk = err_clr ^ multi_bit;
    assign gray_err   = 1'b0;
  end

endmodule

// File: rtl/ptr_cdc_sync_mc.sv
// Multi-channel Gray-pointer synchronizer; slices the pointer bus into
// independent ptr_sync_chan instances.
module ptr_cdc_sync_mc
  import fifo_cdc_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned SYNC_STAGE    = 2,
  parameter int unsigned NUM_CH        = 1,
  parameter bit          GRAY_CHECK    = 1'b1
) (
  input  logic           clk,
  input  logic           s_rst,
  ptr_cdc_sync_mc_if.slave bus
);

  localparam int unsigned PW = ADDRESS_WIDTH + 1;

  if (SYNC_STAGE < SYNC_STAGE_MIN || SYNC_STAGE > SYNC_STAGE_MAX) begin : g_bad_stage
    $error("ptr_cdc_sync_mc: SYNC_STAGE must be in 2..4");
  end
  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_ch
    $error("ptr_cdc_sync_mc: NUM_CH must be in 1..8");
  end
  if (PW > GRAY_W_MAX) begin : g_bad_aw
    $error("ptr_cdc_sync_mc: ADDRESS_WIDTH too large");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ptr_sync_chan #(
      .PW        (PW),
      .SYNC_STAGE(SYNC_STAGE),
      .GRAY_CHECK(GRAY_CHECK)
    ) u_chan (
      .clk      (clk),
      .s_rst    (s_rst),
      .din      (bus.din[c*PW +: PW]),
      .err_clr  (bus.err_clr[c]),
      .sync_gray(bus.sync_gray[c*PW +: PW]),
      .sync_bin (bus.sync_bin[c*PW +: PW]),
      .upd      (bus.upd[c]),
      .adv      (bus.adv[c*PW +: PW]),
      .gray_err (bus.gray_err[c])
    );
  end

endmodule

// File: tb/tb_ptr_cdc_sync_mc.sv
// Directed bench for ptr_cdc_sync_mc: AW=4, SYNC_STAGE=3, four channels.
module tb_ptr_cdc_sync_mc;

  localparam int unsigned AW = 4;
  localparam int unsigned SS = 3;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic s_rst;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ptr_cdc_sync_mc_if #(.ADDRESS_WIDTH(AW), .NUM_CH(NC)) bus ();

  ptr_cdc_sync_mc #(
    .ADDRESS_WIDTH(AW),
    .SYNC_STAGE   (SS),
    .NUM_CH       (NC),
    .GRAY_CHECK   (1'b1)
  ) dut (
    .clk  (clk),
    .s_rst(s_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  int unsigned pulses;
  int unsigned adv_bad;
  bit          wrap_seen;
  bit          err_seen;

  initial begin
    s_rst       = 1'b1;
    bus.din     = '0;
    bus.err_clr = '0;
    tick(3);
    s_rst = 1'b0;
    check("rst_sync_gray", 32'(bus.sync_gray), 32'h0);
    check("rst_sync_bin",  32'(bus.sync_bin),  32'h0);
    check("rst_upd",       32'(bus.upd),       32'h0);
    check("rst_adv",       32'(bus.adv),       32'h0);
    check("rst_gray_err",  32'(bus.gray_err),  32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.upd != 0) pulses++;
    end
    check("hold_no_upd", pulses, 0);

    // single step ch0 Gray 0 -> 1
    bus.din[4:0] = 5'h01;
    tick(SS - 1);
    check("step_sg_early", 32'(bus.sync_gray[4:0]), 32'h0);
    tick();
    check("step_sync_gray", 32'(bus.sync_gray[4:0]), 32'h01);
    check("step_upd_early", 32'(bus.upd), 32'h0);
    tick();
    check("step_sync_bin", 32'(bus.sync_bin[4:0]), 32'h01);
    check("step_upd",      32'(bus.upd),           32'h1);
    check("step_adv",      32'(bus.adv[4:0]),      32'h1);
    tick();
    check("step_upd_off",  32'(bus.upd), 32'h0);
    check("step_adv_off",  32'(bus.adv), 32'h0);

    // walk ch0 from bin 1 through 2..31, 0, 1: 32 steps incl. the 31->0 wrap
    pulses = 0; adv_bad = 0; wrap_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 32 + SS + 1; i++) begin
      if (i < 32) bus.din[4:0] = to_gray(5'((i + 2) % 32));
      tick();
      if (bus.upd[0]) begin
        pulses++;
        if (bus.adv[4:0] != 5'd1) adv_bad++;
        if (bus.sync_bin[4:0] == 5'd0) wrap_seen = 1'b1;
      end
      if (bus.gray_err[0]) err_seen = 1'b1;
    end
    check("wrap_pulses",  pulses, 32);
    check("wrap_adv_bad", adv_bad, 0);
    check("wrap_31_to_0", 32'(wrap_seen), 32'h1);
    check("wrap_no_err",  32'(err_seen), 32'h0);
    tick();
    check("wrap_upd_off", 32'(bus.upd), 32'h0);

    // isolation: step ch2 only (ch0 rests at Gray 1)
    bus.din[14:10] = 5'h01;
    tick(SS + 1);
    check("iso_upd",       32'(bus.upd),       32'h4);
    check("iso_sync_gray", 32'(bus.sync_gray), 32'h00401);
    check("iso_sync_bin",  32'(bus.sync_bin),  32'h00401);
    check("iso_adv",       32'(bus.adv),       32'h00400);
    check("iso_gray_err",  32'(bus.gray_err),  32'h0);

    // illegal jump on ch1: 0 -> 3
    bus.din[9:5] = 5'h03;
    tick(SS);
    check("ill_err_early", 32'(bus.gray_err), 32'h0);
    tick();
    check("ill_err_set",  32'(bus.gray_err), 32'h2);
    check("ill_upd",      32'(bus.upd),      32'h2);
    check("ill_adv",      32'(bus.adv[9:5]), 32'h2);
    tick(3);
    check("ill_err_stick", 32'(bus.gray_err), 32'h2);
    bus.err_clr = 4'b0010;
    tick();
    bus.err_clr = '0;
    check("ill_err_clr", 32'(bus.gray_err), 32'h0);

    // new illegal step 3 -> 0 whose set edge coincides with err_clr
    bus.din[9:5] = 5'h00;
    tick(SS);
    bus.err_clr = 4'b0010;
    tick();
    bus.err_clr = '0;
    check("coinc_set_wins", 32'(bus.gray_err), 32'h2);
    tick();
    check("coinc_stays",    32'(bus.gray_err), 32'h2);

    // reset mid-operation with ch3 at Gray 0x1A
    bus.din[19:15] = 5'h1A;
    tick(SS + 1);
    check("mid_sync_gray", 32'(bus.sync_gray[19:15]), 32'h1A);
    check("mid_sync_bin",  32'(bus.sync_bin[19:15]),  32'h13);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("mrst_sync_gray", 32'(bus.sync_gray), 32'h0);
    check("mrst_sync_bin",  32'(bus.sync_bin),  32'h0);
    check("mrst_upd",       32'(bus.upd),       32'h0);
    check("mrst_adv",       32'(bus.adv),       32'h0);
    check("mrst_gray_err",  32'(bus.gray_err),  32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.upd[3]) pulses++;
      if (i == SS - 2) check("rel_sg_early", 32'(bus.sync_gray), 32'h0);
      if (i == SS - 1) check("rel_sync_gray", 32'(bus.sync_gray), 32'hD0401);
      if (i == SS) begin
        check("rel_upd",      32'(bus.upd),      32'hD);
        check("rel_adv",      32'(bus.adv),      32'h98401);
        check("rel_sync_bin", 32'(bus.sync_bin), 32'h98401);
      end
    end
    check("rel_one_pulse", pulses, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
